// File: rtl/lcd_frame_sink_if.sv
// Framebuffer write bus between lcd_frame_sink and the scan-out RAM.
// A write happens in every cycle where fb_write && fb_ready.
interface lcd_frame_sink_if;
    logic [12:0] fb_adr;
    logic [7:0]  fb_dout;
    logic        fb_write;
    logic        fb_ready;

    modport master (output fb_adr, output fb_dout, output fb_write, input fb_ready);
    modport slave  (input fb_adr, input fb_dout, input fb_write, output fb_ready);
endinterface

// File: rtl/lcd_frame_sink.sv
// lcd_frame_sink: rebuilds PPU pixel stream into packed framebuffer bytes.
// Four 2-bit pixels per byte (first pixel in [7:6]), byte address y*40 + x/4,
// written through a small byte FIFO with a valid/ready handshake.
// Optional macro LCD_FRAME_SINK_ERR_EN builds the sticky err register;
// without it err reads 0 and err_clr is ignored (drop behaviour unchanged).
module lcd_frame_sink #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 144,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             disp_on,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             px_out,
    input  logic [1:0]       px,
    lcd_frame_sink_if.master fb,
    output logic             frame_done,
    output logic [7:0]       frame_cnt,
    output logic [3:0]       err,
    input  logic             err_clr
);
    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  W8         = 8'(WIDTH);
    localparam logic [7:0]  H8         = 8'(HEIGHT);
    localparam logic [12:0] LINE_BYTES = 13'(WIDTH / 4);
    localparam logic [AW:0] FULL_CNT   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SYNC, LINE, VBL} state_t;

    state_t        state, ln_state;
    logic [7:0]    x, y, ln_x, ln_y;
    logic [12:0]   line_base, adr, ln_base, ln_adr;
    logic [5:0]    pack;
    logic          px_take, push, pop, full, wr_ok, head_v, done_sent;
    logic          set_sf, set_sl, set_sp, set_ov;
    logic [20:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;

    // Apply frame/line starts first so a coincident pixel lands at x=0 of the new line
    always_comb begin
        ln_state = state;
        ln_x     = x;
        ln_y     = y;
        ln_base  = line_base;
        ln_adr   = adr;
        set_sf   = 1'b0;
        set_sl   = 1'b0;
        set_sp   = 1'b0;
        px_take  = 1'b0;
        if (disp_on && state != IDLE) begin
            if (vsync) begin
                ln_state = LINE;
                ln_x     = '0;
                ln_y     = '0;
                ln_base  = '0;
                ln_adr   = '0;
                set_sf   = (state == LINE);
            end else if (hsync && state == LINE) begin
                set_sl  = (x != '0) && (x < W8);
                ln_x    = '0;
                ln_y    = y + 8'd1;
                ln_base = line_base + LINE_BYTES;
                ln_adr  = line_base + LINE_BYTES;
                if (ln_y == H8)
                    ln_state = VBL;
            end
            if (px_out) begin
                if (ln_state == LINE && ln_x < W8)
                    px_take = 1'b1;
                else
                    set_sp = 1'b1;
            end
        end
    end

    assign push   = px_take && (ln_x[1:0] == 2'd3);
    assign head_v = (count != '0);
    assign pop    = head_v && fb.fb_ready;
    assign full   = (count == FULL_CNT);
    assign wr_ok  = push && (!full || pop);
    assign set_ov = push && full && !pop;

    assign fb.fb_write = head_v;
    assign fb.fb_adr   = head_v ? mem[rd_ptr][20:8] : '0;
    assign fb.fb_dout  = head_v ? mem[rd_ptr][7:0]  : '0;

    // Frame FSM, pixel packing, FIFO pointers and frame completion
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            line_base  <= '0;
            adr        <= '0;
            pack       <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            done_sent  <= 1'b0;
        end else if (!disp_on) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            line_base  <= '0;
            adr        <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            frame_done <= 1'b0;
            done_sent  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state == IDLE) begin
                state <= SYNC;
            end else begin
                state     <= ln_state;
                x         <= px_take ? ln_x + 8'd1 : ln_x;
                y         <= ln_y;
                line_base <= ln_base;
                adr       <= push ? ln_adr + 13'd1 : ln_adr;
                if (px_take)
                    pack <= {pack[3:0], px};
            end
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW + 1)'(wr_ok) - (AW + 1)'(pop);
            if (state == VBL && !head_v && !done_sent) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 8'd1;
                done_sent  <= 1'b1;
            end else if (state != VBL) begin
                done_sent <= 1'b0;
            end
        end
    end

    // FIFO storage: {address, packed byte}
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= {ln_adr, pack, px};
    end

`ifdef LCD_FRAME_SINK_ERR_EN
    logic [3:0] err_r;

    // Sticky error flags; a new set beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset)
            err_r <= '0;
        else
            err_r <= (err_clr ? 4'b0 : err_r) | {set_ov, set_sp, set_sl, set_sf};
    end

    assign err = err_r;
`else
    logic unused_err;
    assign unused_err = ^{set_ov, set_sp, set_sl, set_sf, err_clr};
    assign err        = '0;
`endif
endmodule

// File: tb/tb_lcd_frame_sink.sv
// Testbench for lcd_frame_sink: random pixel frames, scoreboard of expected
// framebuffer writes computed from line/pixel indices, separate write monitor.
module tb_lcd_frame_sink;
`ifdef LCD_FRAME_SINK_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic       clk, reset, disp_on, hsync, vsync, px_out, err_clr;
    logic [1:0] px;
    logic       frame_done;
    logic [7:0] frame_cnt;
    logic [3:0] err;

    lcd_frame_sink_if fb();

    lcd_frame_sink #(.WIDTH(160), .HEIGHT(144), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .disp_on(disp_on), .hsync(hsync), .vsync(vsync),
        .px_out(px_out), .px(px), .fb(fb), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .err(err), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0, checks = 0;
    logic [20:0] exp_q[$];
    int          writes = 0, done_cnt = 0;
    bit          sb_on = 1'b1, pat_rand = 1'b0, gaps = 1'b0, track = 1'b1;
    int          ready_mode = 0, low_run = 0, cyc = 0;
    bit          hold_v = 1'b0;
    logic [12:0] hold_adr;
    logic [7:0]  hold_dout;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endfunction

    // Write monitor: stability while stalled, scoreboard compare on acceptance
    always @(negedge clk) begin
        logic [20:0] e;
        if (!reset) begin
            if (hold_v && fb.fb_write) begin
                chk("hold fb_adr", 32'(fb.fb_adr), 32'(hold_adr));
                chk("hold fb_dout", 32'(fb.fb_dout), 32'(hold_dout));
            end
            hold_v    = fb.fb_write && !fb.fb_ready;
            hold_adr  = fb.fb_adr;
            hold_dout = fb.fb_dout;
            if (fb.fb_write && fb.fb_ready) begin
                writes++;
                if (sb_on) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected write: got adr %0d data %0h, expected none", fb.fb_adr, fb.fb_dout);
                    end else begin
                        e = exp_q.pop_front();
                        if (fb.fb_adr !== e[20:8] || fb.fb_dout !== e[7:0]) begin
                            errors++;
                            $display("FAIL write: got adr %0d data %0h expected adr %0d data %0h",
                                     fb.fb_adr, fb.fb_dout, e[20:8], e[7:0]);
                        end
                    end
                end
            end
            if (frame_done)
                done_cnt++;
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic step(input logic v, input logic h, input logic po, input logic [1:0] p);
        vsync = v; hsync = h; px_out = po; px = p;
        case (ready_mode)
            0: fb.fb_ready = 1'b1;
            1: if (low_run >= 2 || $urandom_range(0, 3) != 0) begin
                   fb.fb_ready = 1'b1; low_run = 0;
               end else begin
                   fb.fb_ready = 1'b0; low_run++;
               end
            2: fb.fb_ready = (cyc % 4 == 0);
            default: fb.fb_ready = 1'b0;
        endcase
        cyc++;
        @(posedge clk);
        #1;
        vsync = 1'b0; hsync = 1'b0; px_out = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    // One line: hsync (and vsync when vs) rides on the first pixel.
    // Reference: every 4th in-range pixel yields byte at ly*40 + i/4.
    task automatic send_line(input int ly, input int n, input bit vs);
        logic [7:0] acc;
        logic [1:0] p;
        acc = '0;
        if (n == 0) step(vs, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < n; i++) begin
            if (i > 0 && gaps)
                for (int g = 0; g < 3 && $urandom_range(0, 7) == 0; g++) idle(1);
            p = pat_rand ? 2'($urandom_range(0, 3)) : 2'(i % 4);
            step(vs && i == 0, i == 0, 1'b1, p);
            if (i < 160) begin
                acc = {acc[5:0], p};
                if (i % 4 == 3 && track) exp_q.push_back({13'(ly * 40 + i / 4), acc});
            end
        end
    endtask

    task automatic wait_frame(input int target);
        for (int k = 0; k < 100 && done_cnt < target; k++) idle(1);
        idle(5);
        chk("frame_done count", 32'(done_cnt), 32'(target));
    endtask

    initial begin
        int w0;
        reset = 1'b1; disp_on = 1'b0; hsync = 1'b0; vsync = 1'b0; px_out = 1'b0;
        px = 2'd0; err_clr = 1'b0; fb.fb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset fb_write", 32'(fb.fb_write), 0);
        chk("reset fb_adr", 32'(fb.fb_adr), 0);
        chk("reset fb_dout", 32'(fb.fb_dout), 0);
        chk("reset frame_done", 32'(frame_done), 0);
        chk("reset frame_cnt", 32'(frame_cnt), 0);
        chk("reset err", 32'(err), 0);

        // Nominal frame, px = x[1:0], always ready
        disp_on = 1'b1;
        idle(2);
        for (int ly = 0; ly < 144; ly++) send_line(ly, 160, ly == 0);
        step(1'b0, 1'b1, 1'b0, 2'd0);
        wait_frame(1);
        chk("nominal writes", 32'(writes), 5760);
        chk("nominal frame_cnt", 32'(frame_cnt), 1);
        chk("nominal err", 32'(err), 0);
        chk("nominal queue drained", 32'(exp_q.size()), 0);

        // Aborted frame (vsync at y=70), then a random frame with stray and short lines
        pat_rand = 1'b1; gaps = 1'b1; ready_mode = 1;
        for (int ly = 0; ly < 70; ly++) send_line(ly, 160, ly == 0);
        send_line(70, 30, 1'b0);
        for (int ly = 0; ly < 144; ly++)
            send_line(ly, (ly == 0) ? 161 : (ly == 5) ? 100 : (ly == 9) ? 37 : 160, ly == 0);
        step(1'b0, 1'b1, 1'b0, 2'd0);
        wait_frame(2);
        chk("random frame_cnt", 32'(frame_cnt), 2);
        chk("random queue drained", 32'(exp_q.size()), 0);
        chk("err after random frame", 32'(err), ERR_ON ? 32'h7 : 32'h0);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk("err after clear", 32'(err), 0);

        // disp_on dropped at y=10 with three bytes queued behind a stalled RAM
        ready_mode = 0; gaps = 1'b0;
        for (int ly = 0; ly < 10; ly++) send_line(ly, 160, ly == 0);
        idle(3);
        ready_mode = 3; track = 1'b0;
        send_line(10, 12, 1'b0);
        chk("stalled fb_write", 32'(fb.fb_write), 1);
        idle(4);
        w0 = writes;
        disp_on = 1'b0;
        idle(1);
        chk("disp_off fb_write", 32'(fb.fb_write), 0);
        chk("disp_off frame_cnt", 32'(frame_cnt), 2);
        ready_mode = 0;
        idle(4);
        chk("disp_off no writes", 32'(writes - w0), 0);
        chk("disp_off queue", 32'(exp_q.size()), 0);
        chk("disp_off err", 32'(err), 0);

        // Backpressure: slow RAM, then a stalled line forces overflow
        sb_on = 1'b0; pat_rand = 1'b0;
        disp_on = 1'b1;
        idle(2);
        w0 = writes;
        ready_mode = 2;
        send_line(0, 160, 1'b1);
        ready_mode = 3;
        send_line(1, 160, 1'b0);
        ready_mode = 0;
        idle(10);
        chk("backpressure writes below 80", 32'((writes - w0) < 80), 1);
        chk("backpressure overflow flag", 32'(err[3]), 32'(ERR_ON));

        // Reset mid-line with a byte pending
        ready_mode = 3;
        send_line(0, 6, 1'b1);
        chk("pending before reset", 32'(fb.fb_write), 1);
        reset = 1'b1;
        idle(1);
        chk("midreset fb_write", 32'(fb.fb_write), 0);
        chk("midreset fb_adr", 32'(fb.fb_adr), 0);
        chk("midreset fb_dout", 32'(fb.fb_dout), 0);
        chk("midreset frame_done", 32'(frame_done), 0);
        chk("midreset frame_cnt", 32'(frame_cnt), 0);
        chk("midreset err", 32'(err), 0);
        reset = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
